// File: rtl/mips_run_checker.sv
// End-of-run monitor: detects halt (stable PC) or timeout, then scans the
// register file against expected values and reports pass/fail.
// Ports: clk, reset, start, pc_in; rf_addr/rf_data/exp_data (+exp_mask) scan
// port; busy, done, pass, timeout, mismatch_cnt, first_bad, final_pc,
// cycle_cnt results. Macro RUN_CHK_MASK_EN adds the exp_mask compare mask.
module mips_run_checker #(
  parameter int DATA_W        = 32,
  parameter int NUM_REGS      = 32,
  parameter int ADDR_W        = 5,
  parameter int PC_W          = 32,
  parameter int CYC_W         = 24,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_CYCLES    = 6232
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   pc_in,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] exp_data,
`ifdef RUN_CHK_MASK_EN
  input  logic [DATA_W-1:0] exp_mask,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ADDR_W:0]   mismatch_cnt,
  output logic [ADDR_W-1:0] first_bad,
  output logic [PC_W-1:0]   final_pc,
  output logic [CYC_W-1:0]  cycle_cnt
);

  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CYC_W-1:0]  MAX_C  = CYC_W'(MAX_CYCLES);
  localparam logic [STB_W-1:0]  STB_C  = STB_W'(STABLE_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SCAN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PC_W-1:0]  prev_pc;
  logic [STB_W-1:0] stable;
  logic [STB_W-1:0] stb_inc;
  logic [CYC_W-1:0] cyc_inc;
  logic             halt;
  logic             hit_max;
  logic             last;
  logic             diff;
  logic             clr;

  always_comb begin
    cyc_inc = cycle_cnt;
    if (cycle_cnt != MAX_C) begin
      cyc_inc = cycle_cnt + 1'b1;
    end
    stb_inc = '0;
    if (pc_in == prev_pc) begin
      stb_inc = stable + 1'b1;
    end
    halt    = (stb_inc >= STB_C);
    hit_max = (cyc_inc == MAX_C);
    last    = (rf_addr == LAST_A);
`ifdef RUN_CHK_MASK_EN
    diff    = (((rf_data ^ exp_data) & exp_mask) != '0);
`else
    diff    = (rf_data != exp_data);
`endif
    clr     = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (halt || hit_max) state_nx = SCAN;
      SCAN: if (last) state_nx = DONE;
      DONE: if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc      <= '0;
      stable       <= '0;
      rf_addr      <= '0;
      timeout      <= 1'b0;
      mismatch_cnt <= '0;
      first_bad    <= '0;
      final_pc     <= '0;
      cycle_cnt    <= '0;
    end else begin
      prev_pc <= pc_in;
      if (clr) begin
        cycle_cnt    <= '0;
        mismatch_cnt <= '0;
        first_bad    <= '0;
        timeout      <= 1'b0;
        stable       <= '0;
      end
      if (state == RUN) begin
        cycle_cnt <= cyc_inc;
        stable    <= stb_inc;
        if (halt || hit_max) begin
          final_pc <= pc_in;
          // halt takes priority when both fire together
          timeout  <= !halt;
          rf_addr  <= '0;
        end
      end
      if (state == SCAN) begin
        if (diff) begin
          mismatch_cnt <= mismatch_cnt + 1'b1;
          if (mismatch_cnt == '0) begin
            first_bad <= rf_addr;
          end
        end
        if (!last) begin
          rf_addr <= rf_addr + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy = (state == RUN) || (state == SCAN);
    done = (state == DONE);
    pass = done && (mismatch_cnt == '0) && !timeout;
  end

endmodule

// File: tb/tb_mips_run_checker.sv
// Directed bench for mips_run_checker (MAX_CYCLES=100, STABLE_CYCLES=4,
// NUM_REGS=32); each task drives one scenario and checks inline.
module tb_mips_run_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pc_in;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] exp_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [5:0]  mismatch_cnt;
  logic [4:0]  first_bad;
  logic [31:0] final_pc;
  logic [23:0] cycle_cnt;

  logic [31:0] rf_mem  [32];
  logic [31:0] exp_mem [32];
`ifdef RUN_CHK_MASK_EN
  logic [31:0] exp_mask;
  logic [31:0] mask_mem [32];
  assign exp_mask = mask_mem[rf_addr];
`endif

  assign rf_data  = rf_mem[rf_addr];
  assign exp_data = exp_mem[rf_addr];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_run_checker #(
    .MAX_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pc_in(pc_in),
    .rf_addr(rf_addr),
    .rf_data(rf_data),
    .exp_data(exp_data),
`ifdef RUN_CHK_MASK_EN
    .exp_mask(exp_mask),
`endif
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .mismatch_cnt(mismatch_cnt),
    .first_bad(first_bad),
    .final_pc(final_pc),
    .cycle_cnt(cycle_cnt)
  );

  task automatic init_mem();
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]  = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      exp_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
`ifdef RUN_CHK_MASK_EN
      mask_mem[i] = 32'hFFFF_FFFF;
`endif
    end
  endtask

  // PC runs 0,4,8.. for n_inc cycles then holds (or never holds);
  // busy_n counts sampled busy cycles from the first RUN cycle to done.
  task automatic run(input int n_inc, input bit never_stable,
                     input int start_at, output int busy_n,
                     output bit ok);
    @(negedge clk);
    start = 1'b1;
    pc_in = 32'hDEAD_BEEC;
    @(negedge clk);
    start  = 1'b0;
    busy_n = 0;
    ok     = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_n++;
      start = (k == start_at);
      if (never_stable || k < n_inc) pc_in = 32'(k * 4);
      else pc_in = 32'((n_inc - 1) * 4);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    pc_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, timeout} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000",
               {busy, done, pass, timeout});
    end
    checks++;
    if ({rf_addr, mismatch_cnt, first_bad, final_pc, cycle_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_values addr=%0d mis=%0d fb=%0d pc=%h cyc=%0d",
               rf_addr, mismatch_cnt, first_bad, final_pc, cycle_cnt);
    end
  endtask

  task automatic test_halt_pass();
    int bn;
    bit ok;
    init_mem();
    run(16, 1'b0, -1, bn, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL halt_done got=timeout_wait want=done");
    end
    checks++;
    if ({pass, timeout} !== 2'b10) begin
      failures++;
      $display("FAIL halt_pass got=%b want=10", {pass, timeout});
    end
    checks++;
    if (final_pc !== 32'h3C || mismatch_cnt !== 6'd0) begin
      failures++;
      $display("FAIL halt_pc got=%h/%0d want=3c/0", final_pc, mismatch_cnt);
    end
    checks++;
    if (cycle_cnt !== 24'd20 || bn != 52 || rf_addr !== 5'd31) begin
      failures++;
      $display("FAIL halt_timing got cyc=%0d busy=%0d addr=%0d want 20/52/31",
               cycle_cnt, bn, rf_addr);
    end
  endtask

  task automatic test_mismatch();
    int bn;
    bit ok;
    init_mem();
    rf_mem[9]  = 32'h6;
    exp_mem[9] = 32'h5;
    rf_mem[20] = rf_mem[20] ^ 32'h8000_0000;
    run(16, 1'b0, -1, bn, ok);
    checks++;
    if (!ok || pass !== 1'b0) begin
      failures++;
      $display("FAIL mis_pass got ok=%0d pass=%b want 1/0", ok, pass);
    end
    checks++;
    if (mismatch_cnt !== 6'd2 || first_bad !== 5'd9) begin
      failures++;
      $display("FAIL mis_count got=%0d/%0d want=2/9",
               mismatch_cnt, first_bad);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h100 + 32'(i);
      @(negedge clk);
      checks++;
      if (!done || mismatch_cnt !== 6'd2 || first_bad !== 5'd9 ||
          final_pc !== 32'h3C || cycle_cnt !== 24'd20) begin
        failures++;
        $display("FAIL hold_%0d got d=%b m=%0d f=%0d pc=%h c=%0d", i,
                 done, mismatch_cnt, first_bad, final_pc, cycle_cnt);
      end
    end
    init_mem();
    pc_in = 32'h200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (mismatch_cnt !== 6'd0 || first_bad !== 5'd0 ||
        cycle_cnt !== 24'd0 || {busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL restart_clear got m=%0d f=%0d c=%0d bd=%b want 0/0/0/10",
               mismatch_cnt, first_bad, cycle_cnt, {busy, done});
    end
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok || pass !== 1'b1 || cycle_cnt !== 24'd4 ||
        final_pc !== 32'h200) begin
      failures++;
      $display("FAIL min_halt got ok=%0d p=%b c=%0d pc=%h want 1/1/4/200",
               ok, pass, cycle_cnt, final_pc);
    end
  endtask

  task automatic test_timeout();
    int bn;
    bit ok;
    init_mem();
    run(0, 1'b1, -1, bn, ok);
    checks++;
    if (!ok || timeout !== 1'b1 || pass !== 1'b0) begin
      failures++;
      $display("FAIL tmo_flags got ok=%0d t=%b p=%b want 1/1/0",
               ok, timeout, pass);
    end
    checks++;
    if (cycle_cnt !== 24'd100 || final_pc !== 32'd396 || bn != 132) begin
      failures++;
      $display("FAIL tmo_values got c=%0d pc=%0d busy=%0d want 100/396/132",
               cycle_cnt, final_pc, bn);
    end
  endtask

  task automatic test_halt_wins();
    int bn;
    bit ok;
    init_mem();
    run(96, 1'b0, -1, bn, ok);
    checks++;
    if (!ok || timeout !== 1'b0 || pass !== 1'b1) begin
      failures++;
      $display("FAIL tie_flags got ok=%0d t=%b p=%b want 1/0/1",
               ok, timeout, pass);
    end
    checks++;
    if (cycle_cnt !== 24'd100 || final_pc !== 32'd380 || bn != 132) begin
      failures++;
      $display("FAIL tie_values got c=%0d pc=%0d busy=%0d want 100/380/132",
               cycle_cnt, final_pc, bn);
    end
  endtask

  task automatic test_start_ignored();
    int bn;
    bit ok;
    init_mem();
    run(16, 1'b0, 5, bn, ok);
    checks++;
    if (!ok || cycle_cnt !== 24'd20 || bn != 52) begin
      failures++;
      $display("FAIL start_in_run got ok=%0d c=%0d busy=%0d want 1/20/52",
               ok, cycle_cnt, bn);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit hit;
    init_mem();
    exp_mem[3] = 32'h1;
    @(negedge clk);
    start = 1'b1;
    pc_in = 32'h40;
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (busy && rf_addr == 5'd12) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit || mismatch_cnt !== 6'd1) begin
      failures++;
      $display("FAIL scan_reach got hit=%0d m=%0d want 1/1",
               hit, mismatch_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, pass, timeout} !== 4'b0000 ||
        {rf_addr, mismatch_cnt, first_bad, final_pc, cycle_cnt} !== '0) begin
      failures++;
      $display("FAIL mid_reset got bdpt=%b a=%0d m=%0d f=%0d pc=%h c=%0d",
               {busy, done, pass, timeout}, rf_addr, mismatch_cnt,
               first_bad, final_pc, cycle_cnt);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got bd=%b want 00", {busy, done});
    end
  endtask

`ifdef RUN_CHK_MASK_EN
  task automatic test_mask();
    int bn;
    bit ok;
    init_mem();
    mask_mem[26] = 32'h0;
    rf_mem[26]   = ~exp_mem[26];
    run(16, 1'b0, -1, bn, ok);
    checks++;
    if (!ok || pass !== 1'b1 || mismatch_cnt !== 6'd0) begin
      failures++;
      $display("FAIL mask_skip got ok=%0d p=%b m=%0d want 1/1/0",
               ok, pass, mismatch_cnt);
    end
    init_mem();
    for (int i = 0; i < 32; i++) mask_mem[i] = 32'h8;
    rf_mem[5] = rf_mem[5] ^ 32'h8;
    rf_mem[7] = rf_mem[7] ^ 32'h1;
    run(16, 1'b0, -1, bn, ok);
    checks++;
    if (!ok || mismatch_cnt !== 6'd1 || first_bad !== 5'd5 ||
        pass !== 1'b0) begin
      failures++;
      $display("FAIL mask_bit3 got ok=%0d m=%0d f=%0d p=%b want 1/1/5/0",
               ok, mismatch_cnt, first_bad, pass);
    end
  endtask
`endif

  initial begin
    init_mem();
    test_reset();
    test_halt_pass();
    test_mismatch();
    test_back_to_back();
    test_timeout();
    test_halt_wins();
    test_start_ignored();
    test_reset_mid_scan();
`ifdef RUN_CHK_MASK_EN
    test_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
